// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
//   Shares the single combinational IMEM read port between the fetch stage
//   (port F) and a data-side/debug reader (port D). Each port has a
//   valid/ready request handshake and a registered response that appears one
//   cycle after acceptance. Ties are resolved round-robin. Every access is
//   checked for word alignment and for being inside the IMEM. A failing
//   access returns NOP_WORD with the err flag set.
//
//   Build option:
//     IMEM_ARB_FETCH_PRIO_EN - when defined, F has strict priority over D.
//                              When undefined, ties alternate (default).
//
//   Ports:
//     clk, rst         rising-edge clock; asynchronous active-high reset
//     f_req_*          fetch request (valid/ready, byte address)
//     f_flush          fetch redirect: drop the F response, no F grant
//     f_rsp_*          fetch response (valid/ready, data, err)
//     d_req_*, d_rsp_* D-port request/response, same shape as F
//     mem_addr         byte address driven to the IMEM
//     mem_rdata        combinational IMEM read data for mem_addr

// Per-port response register. A load takes priority over a clear, so a
// back-to-back grant keeps rsp_valid high. Data and err hold when cleared.
module imem_rsp_slot #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        load_err,
  input  logic        flush,
  input  logic        rsp_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= NOP_WORD;
      rsp_err   <= 1'b0;
    end else if (load) begin
      rsp_valid <= 1'b1;
      rsp_data  <= load_data;
      rsp_err   <= load_err;
    end else if (flush || rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

module imem_port_arbiter #(
  parameter int unsigned IMEM_WORDS = 256,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req_valid,
  input  logic [31:0] f_req_addr,
  output logic        f_req_ready,
  input  logic        f_flush,
  output logic        f_rsp_valid,
  output logic [31:0] f_rsp_data,
  output logic        f_rsp_err,
  input  logic        f_rsp_ready,
  input  logic        d_req_valid,
  input  logic [31:0] d_req_addr,
  output logic        d_req_ready,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic        d_rsp_err,
  input  logic        d_rsp_ready,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata
);
  localparam int NUM_PORTS = 2;
  localparam int PF = 0;
  localparam int PD = 1;
  // 33 bits so that IMEM_WORDS*4 cannot wrap.
  localparam logic [32:0] ADDR_LIMIT = 33'(IMEM_WORDS) << 2;

  logic [NUM_PORTS-1:0]       req_vld, rsp_rdy, rsp_vld, rsp_err, flush_vec;
  logic [NUM_PORTS-1:0]       elig, grant, addr_err;
  logic [NUM_PORTS-1:0][31:0] req_addr, rsp_data;
  logic [31:0]                load_data;
  logic                       rr_last;  // 1: D held the most recent grant

  assign req_vld   = {d_req_valid, f_req_valid};
  assign req_addr  = {d_req_addr, f_req_addr};
  assign rsp_rdy   = {d_rsp_ready, f_rsp_ready};
  assign flush_vec = {1'b0, f_flush};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign addr_err[p] = (req_addr[p][1:0] != 2'b00) ||
                         ({1'b0, req_addr[p]} >= ADDR_LIMIT);
    // A port holding an unconsumed response cannot accept another request.
    assign elig[p] = req_vld[p] && !flush_vec[p] && (!rsp_vld[p] || rsp_rdy[p]);

    imem_rsp_slot #(.NOP_WORD(NOP_WORD)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (grant[p]),
      .load_data (load_data),
      .load_err  (addr_err[p]),
      .flush     (flush_vec[p]),
      .rsp_ready (rsp_rdy[p]),
      .rsp_valid (rsp_vld[p]),
      .rsp_data  (rsp_data[p]),
      .rsp_err   (rsp_err[p])
    );
  end

  always_comb begin
    grant = '0;
`ifdef IMEM_ARB_FETCH_PRIO_EN
    grant[PF] = elig[PF];
    grant[PD] = elig[PD] && !elig[PF];
`else
    if (elig[PF] && elig[PD]) begin
      grant[PF] = rr_last;
      grant[PD] = !rr_last;
    end else begin
      grant = elig;
    end
`endif
  end

  // The address mux defaults to F so that the IMEM sees a stable fetch address when idle.
  assign mem_addr  = grant[PD] ? d_req_addr : f_req_addr;
  // Only the granted slot loads, so the error of the port that owns mem_addr decides.
  assign load_data = addr_err[grant[PD] ? PD : PF] ? NOP_WORD : mem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        rr_last <= 1'b1;
    else if (|grant) rr_last <= grant[PD];
  end

  assign f_req_ready = grant[PF];
  assign d_req_ready = grant[PD];
  assign f_rsp_valid = rsp_vld[PF];
  assign f_rsp_data  = rsp_data[PF];
  assign f_rsp_err   = rsp_err[PF];
  assign d_rsp_valid = rsp_vld[PD];
  assign d_rsp_data  = rsp_data[PD];
  assign d_rsp_err   = rsp_err[PD];
endmodule

// File: tb/tb_imem_port_arbiter.sv
module tb_imem_port_arbiter;
  localparam int          W   = 256;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IMEM_ARB_FETCH_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        clk = 1'b0, rst;
  logic        f_req_valid, f_req_ready, f_flush, f_rsp_valid, f_rsp_err, f_rsp_ready;
  logic        d_req_valid, d_req_ready, d_rsp_valid, d_rsp_err, d_rsp_ready;
  logic [31:0] f_req_addr, f_rsp_data, d_req_addr, d_rsp_data, mem_addr, mem_rdata;
  logic        ovr_en;
  logic [31:0] ovr_data;

  imem_port_arbiter #(.IMEM_WORDS(W), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst),
    .f_req_valid(f_req_valid), .f_req_addr(f_req_addr), .f_req_ready(f_req_ready),
    .f_flush(f_flush), .f_rsp_valid(f_rsp_valid), .f_rsp_data(f_rsp_data),
    .f_rsp_err(f_rsp_err), .f_rsp_ready(f_rsp_ready),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .d_rsp_ready(d_rsp_ready), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F11;
  endfunction
  assign mem_rdata = ovr_en ? ovr_data : mem_fn(mem_addr);

  function automatic bit bad(input logic [31:0] a);
    return (a % 4 != 0) || (64'(a) >= 64'(W) * 4);
  endfunction

  // Reference state: per-port response contents and the last granted port.
  bit          m_vld [2];
  logic [31:0] m_data[2];
  bit          m_err [2];
  int          last;
  int          win;
  int          n_cmp = 0, n_bad = 0;

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin m_vld[p] = 0; m_data[p] = NOP; m_err[p] = 0; end
    last = 1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Settle mid-cycle, decide the winner from the rules and compare every output.
  task automatic eval();
    bit ef, ed;
    #2;
    ef = f_req_valid && !f_flush && (!m_vld[0] || f_rsp_ready);
    ed = d_req_valid && (!m_vld[1] || d_rsp_ready);
    if (ef && ed)  win = PRIO ? 0 : 1 - last;
    else if (ef)   win = 0;
    else if (ed)   win = 1;
    else           win = -1;
    chk("f_req_ready", 32'(f_req_ready), 32'(win == 0));
    chk("d_req_ready", 32'(d_req_ready), 32'(win == 1));
    chk("mem_addr", mem_addr, (win == 1) ? d_req_addr : f_req_addr);
    chk("f_rsp_valid", 32'(f_rsp_valid), 32'(m_vld[0]));
    chk("f_rsp_data", f_rsp_data, m_data[0]);
    chk("f_rsp_err", 32'(f_rsp_err), 32'(m_err[0]));
    chk("d_rsp_valid", 32'(d_rsp_valid), 32'(m_vld[1]));
    chk("d_rsp_data", d_rsp_data, m_data[1]);
    chk("d_rsp_err", 32'(d_rsp_err), 32'(m_err[1]));
  endtask

  task automatic tick();
    logic [31:0] a;
    @(posedge clk);
    for (int p = 0; p < 2; p++) begin
      if (win == p) begin
        a         = p ? d_req_addr : f_req_addr;
        m_vld[p]  = 1;
        m_err[p]  = bad(a);
        m_data[p] = bad(a) ? NOP : (ovr_en ? ovr_data : mem_fn(a));
      end else if (p == 0 && f_flush) begin
        m_vld[0] = 0;
      end else if (m_vld[p] && (p ? d_rsp_ready : f_rsp_ready)) begin
        m_vld[p] = 0;
      end
    end
    if (win >= 0) last = win;
    #1;
  endtask

  task automatic idle();
    f_req_valid = 0; d_req_valid = 0; f_flush = 0;
  endtask

  // Reset mid-cycle with no requests pending, release away from any edge.
  task automatic pulse_reset();
    idle();
    #2 rst = 1;
    #1;
    chk("rst f_rsp_valid", 32'(f_rsp_valid), 32'd0);
    chk("rst d_rsp_valid", 32'(d_rsp_valid), 32'd0);
    chk("rst f_rsp_data", f_rsp_data, NOP);
    chk("rst d_rsp_data", d_rsp_data, NOP);
    chk("rst f_rsp_err", 32'(f_rsp_err), 32'd0);
    model_reset();
    @(posedge clk);
    #2 rst = 0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_addr();
    int r = $urandom_range(0, 9);
    if (r < 7)       return {22'd0, 8'($urandom_range(0, W - 1)), 2'b00};
    else if (r == 7) return {22'd0, 8'($urandom_range(0, W - 1)), 2'($urandom_range(1, 3))};
    else if (r == 8) return 32'(W * 4 + $urandom_range(0, 64));
    else             return $urandom;
  endfunction

  logic [31:0] held;

  initial begin
    rst = 1; idle(); ovr_en = 0; ovr_data = 0;
    f_req_addr = 0; d_req_addr = 0; f_rsp_ready = 1; d_rsp_ready = 1;
    model_reset();
    #3;
    chk("init f_rsp_valid", 32'(f_rsp_valid), 32'd0);
    chk("init d_rsp_data", d_rsp_data, NOP);
    #9 rst = 0;
    @(posedge clk); #1;

    // First fetch: one-cycle latency with a known instruction word.
    ovr_en = 1; ovr_data = 32'h0050_0093;
    f_req_valid = 1; f_req_addr = 32'h0;
    eval();
    chk("t1 f_req_ready", 32'(f_req_ready), 32'd1);
    tick();
    f_req_valid = 0;
    eval();
    chk("t1 f_rsp_valid", 32'(f_rsp_valid), 32'd1);
    chk("t1 f_rsp_data", f_rsp_data, 32'h0050_0093);
    chk("t1 f_rsp_err", 32'(f_rsp_err), 32'd0);
    tick();
    ovr_en = 0;

    // Continuous contention after reset: F first, then alternate.
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      f_req_valid = 1; d_req_valid = 1; f_rsp_ready = 1; d_rsp_ready = 1;
      f_req_addr = 32'(i * 8); d_req_addr = 32'(i * 8 + 4);
      eval();
      chk("alt f_req_ready", 32'(f_req_ready), 32'(PRIO || (i % 2 == 0)));
      chk("alt d_req_ready", 32'(d_req_ready), 32'(!PRIO && (i % 2 == 1)));
      tick();
    end
    idle(); eval(); tick();

    // Misaligned and out-of-range D accesses.
    d_req_valid = 1; d_req_addr = 32'h0000_0402;
    eval(); tick();
    d_req_addr = 32'h0000_0400;
    eval();
    chk("mis d_rsp_err", 32'(d_rsp_err), 32'd1);
    chk("mis d_rsp_data", d_rsp_data, NOP);
    tick();
    d_req_valid = 0;
    eval();
    chk("oor d_rsp_err", 32'(d_rsp_err), 32'd1);
    chk("oor d_rsp_data", d_rsp_data, NOP);
    tick();

    // F response held; D keeps flowing.
    f_req_valid = 1; f_req_addr = 32'h40; f_rsp_ready = 1;
    eval(); tick();
    held = mem_fn(32'h40);
    for (int i = 0; i < 3; i++) begin
      f_rsp_ready = 0; f_req_addr = 32'h44;
      d_req_valid = 1; d_req_addr = 32'(i * 4 + 32'h100); d_rsp_ready = 1;
      eval();
      chk("hold f_req_ready", 32'(f_req_ready), 32'd0);
      chk("hold d_req_ready", 32'(d_req_ready), 32'd1);
      chk("hold f_rsp_data", f_rsp_data, held);
      tick();
    end

    // Flush with a held response and a competing D request.
    f_flush = 1; d_req_addr = 32'h200;
    eval();
    chk("flush f_req_ready", 32'(f_req_ready), 32'd0);
    chk("flush d_req_ready", 32'(d_req_ready), 32'd1);
    tick();
    idle(); f_rsp_ready = 1;
    eval();
    chk("flush f_rsp_valid", 32'(f_rsp_valid), 32'd0);
    tick();

    // Reset the cycle after a grant, then F wins the first tie.
    f_req_valid = 1; f_req_addr = 32'h10;
    eval(); tick();
    pulse_reset();
    f_req_valid = 1; d_req_valid = 1; f_req_addr = 32'h20; d_req_addr = 32'h24;
    eval();
    chk("post-rst f_req_ready", 32'(f_req_ready), 32'd1);
    chk("post-rst d_req_ready", 32'(d_req_ready), 32'd0);
    tick();

    // Random traffic against the model.
    for (int c = 0; c < 500; c++) begin
      f_req_valid = ($urandom_range(0, 3) != 0);
      d_req_valid = ($urandom_range(0, 3) != 0);
      f_req_addr  = rnd_addr();
      d_req_addr  = rnd_addr();
      f_flush     = ($urandom_range(0, 7) == 0);
      f_rsp_ready = ($urandom_range(0, 3) != 0);
      d_rsp_ready = ($urandom_range(0, 3) != 0);
      eval(); tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
Shares the single combinational instruction-memory read port between the core fetch stage (port F) and a data-side/debug reader (port D, e.g. constant loads or a debug monitor). Per-port valid/ready request handshake with round-robin arbitration. Registered response, one cycle after acceptance. Also performs alignment and range checking.
Sits between the fetch stage and the IMEM. It drives the IMEM address and samples the IMEM read data.

Parameters:
IMEM_WORDS, 256, number of 32-bit words in the instruction memory; legal byte addresses are 0 .. IMEM_WORDS*4-1
NOP_WORD, 32'h00000013, data returned on an erroneous access

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
f_req_valid  input  1  fetch request valid
f_req_addr  input  32  fetch byte address
f_req_ready  output  1  fetch request accepted this cycle
f_flush  input  1  fetch redirect: discard pending/held fetch response, block F grant this cycle
f_rsp_valid  output  1  fetch response valid
f_rsp_data  output  32  fetch instruction word
f_rsp_err  output  1  fetch address misaligned or out of range
f_rsp_ready  input  1  fetch consumer accepts response
d_req_valid  input  1  D-port request valid
d_req_addr  input  32  D-port byte address
d_req_ready  output  1  D-port request accepted this cycle
d_rsp_valid  output  1  D-port response valid
d_rsp_data  output  32  D-port read word
d_rsp_err  output  1  D-port address misaligned or out of range
d_rsp_ready  input  1  D-port consumer accepts response
mem_addr  output  32  byte address to IMEM
mem_rdata  input  32  combinational IMEM read data for mem_addr

Behaviour:
- Reset (async, immediate): f_rsp_valid = d_rsp_valid = 0; rsp_data = NOP_WORD; rsp_err = 0; rr_last = D, so F wins the first tie. Any outstanding response is discarded.
- Eligibility (combinational):
  - elig_F = f_req_valid && !f_flush && (!f_rsp_valid || f_rsp_ready)
  - elig_D = d_req_valid && (!d_rsp_valid || d_rsp_ready)
- Grant (combinational, same cycle):
  - Only one eligible: grant it.
  - Both eligible: grant the port opposite rr_last.
  - Neither eligible: no grant.
- x_req_ready = grant_x. Never asserted for both ports in one cycle.
- mem_addr = granted port's address. With no grant or F granted, mem_addr = f_req_addr.
- err = (addr[1:0] != 0) || (addr >= IMEM_WORDS*4), computed with 33-bit compare so there is no overflow.
- On the rising edge with grant_x:
  - x_rsp_valid <= 1
  - x_rsp_data <= err ? NOP_WORD : mem_rdata
  - x_rsp_err <= err
  - rr_last <= x
  - Latency: request accepted in cycle N, response valid in cycle N+1.
- Back-to-back: with a new grant and rsp_ready in the same cycle, the response register is reloaded and x_rsp_valid stays 1. Full throughput is one access per port per cycle when uncontended.
- Response hold: with x_rsp_valid=1 and x_rsp_ready=0, data and err are held stable and that port is not eligible.
- With x_rsp_valid && x_rsp_ready and no new grant: x_rsp_valid <= 0; data and err are held.
- f_flush:
  - Next edge: f_rsp_valid <= 0, regardless of f_rsp_ready.
  - No F grant in the flush cycle.
  - D traffic is unaffected, and D may be granted in that cycle.
  - rr_last is unchanged unless D is granted.
- rr_last changes only on a grant. Without the optional feature, two continuously-eligible ports alternate F, D, F, D.

Optional Feature:
IMEM_ARB_FETCH_PRIO_EN
- Defined: F has strict priority. D is granted only when elig_F=0. rr_last is still updated but ignored.
- Undefined: round-robin as above.

Test Plan:
- Reset, F req addr 0x0 with mem_rdata=0x00500093 → f_req_ready=1 in cycle 0, f_rsp_valid=1 and f_rsp_data=0x00500093, f_rsp_err=0 in cycle 1.
- F and D both requesting every cycle, rsp_ready=1 → grants alternate F, D, F, D starting with F. With IMEM_ARB_FETCH_PRIO_EN, D is never granted.
- D addr 0x0000_0402 (misaligned), then 0x0000_0400 (IMEM_WORDS=256, out of range) → d_rsp_err=1, d_rsp_data=0x00000013 both times.
- F response held with f_rsp_ready=0 for 3 cycles → f_req_ready=0, f_rsp_data stable. D continues to be granted every cycle.
- f_flush asserted with f_rsp_valid=1 and f_req_valid=1 → f_req_ready=0 that cycle, f_rsp_valid=0 next cycle; a D request in the same cycle is granted.
- Assert rst mid-transfer, cycle after a grant → all rsp_valid drop to 0 immediately, rsp_data=NOP_WORD. First grant after release goes to F on a tie.
